// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle datapath and its control FSM.
// master = control FSM side, slave = datapath side.
interface multicycle_control_fsm_if #(
    parameter int ALU_OP_W = 2
);
    // Datapath status into the FSM
    logic [6:0]          opcode;
    logic                bcond;
    logic                mem_ready;
    logic                is_halt;

    // Control strobes out of the FSM
    logic                pc_write;
    logic                IorD;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                ir_write;
    logic                pc_src;
    logic                alu_srcA;
    logic                reg_write;
    logic                halted;
    logic                trapped;
    logic                mem_timeout;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          alu_srcB;
    logic [3:0]          state;

    modport master (
        input  opcode,
        input  bcond,
        input  mem_ready,
        input  is_halt,
        output pc_write,
        output IorD,
        output mem_read,
        output mem_write,
        output mem_to_reg,
        output ir_write,
        output pc_src,
        output alu_srcA,
        output reg_write,
        output halted,
        output trapped,
        output mem_timeout,
        output alu_op,
        output alu_srcB,
        output state
    );

    modport slave (
        output opcode,
        output bcond,
        output mem_ready,
        output is_halt,
        input  pc_write,
        input  IorD,
        input  mem_read,
        input  mem_write,
        input  mem_to_reg,
        input  ir_write,
        input  pc_src,
        input  alu_srcA,
        input  reg_write,
        input  halted,
        input  trapped,
        input  mem_timeout,
        input  alu_op,
        input  alu_srcB,
        input  state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 control FSM with Moore-style strobes decoded from the registered state.
// Define MEM_TIMEOUT_EN to add a memory-wait watchdog that traps after 2^TIMEOUT_W-1 stalls.
module multicycle_control_fsm #(
    parameter int ALU_OP_W  = 2,
    parameter int TIMEOUT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        StIf      = 4'd0,
        StId      = 4'd1,
        StExR     = 4'd2,
        StExI     = 4'd3,
        StExAddr  = 4'd4,
        StMemLd   = 4'd5,
        StMemSt   = 4'd6,
        StWbAlu   = 4'd7,
        StWbLd    = 4'd8,
        StExBr    = 4'd9,
        StBrTake  = 4'd10,
        StExJal   = 4'd11,
        StExJalr  = 4'd12,
        StEcall   = 4'd13,
        StHalt    = 4'd14,
        StTrap    = 4'd15
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [ALU_OP_W-1:0] AluAdd   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] AluFunct = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] AluBr    = ALU_OP_W'(2);

    localparam logic [1:0] SrcBRs2  = 2'd0;
    localparam logic [1:0] SrcBFour = 2'd1;
    localparam logic [1:0] SrcBImm  = 2'd2;

    if (ALU_OP_W < 2 || TIMEOUT_W < 1) begin : g_param_check
        $error("multicycle_control_fsm: ALU_OP_W must be >= 2 and TIMEOUT_W >= 1");
    end

    state_e              r_state;
    state_e              w_state_next;
    logic                w_timeout;

    logic                w_pc_write;
    logic                w_iord;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_mem_to_reg;
    logic                w_ir_write;
    logic                w_pc_src;
    logic                w_alu_src_a;
    logic                w_reg_write;
    logic                w_halted;
    logic                w_trapped;
    logic [ALU_OP_W-1:0] w_alu_op;
    logic [1:0]          w_alu_src_b;

`ifdef MEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WaitLast = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

    logic                 w_mem_state;
    logic [TIMEOUT_W-1:0] r_wait;
    logic [TIMEOUT_W-1:0] w_wait_next;

    assign w_mem_state = (r_state == StIf) || (r_state == StMemLd) || (r_state == StMemSt);

    // Counter is zero on entry to every memory state, so only stalled memory cycles count.
    always_comb begin
        w_wait_next = '0;
        if (w_mem_state && !bus.mem_ready) begin
            w_wait_next = r_wait + TIMEOUT_W'(1);
        end
    end

    // This stall would bring the counter to its all-ones limit.
    assign w_timeout = w_mem_state && !bus.mem_ready && (r_wait == WaitLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else begin
            r_wait <= w_wait_next;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIf;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src_a  = 1'b0;
        w_reg_write  = 1'b0;
        w_halted     = 1'b0;
        w_trapped    = 1'b0;
        w_alu_op     = AluAdd;
        w_alu_src_b  = SrcBRs2;

        unique case (r_state)
            StIf: begin
                w_mem_read = 1'b1;
                w_ir_write = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_state_next = StId;
                end else if (w_timeout) begin
                    w_state_next = StTrap;
                end
            end
            StId: begin
                // ALUOut <- PC + 4, reused as the fall-through PC by later states
                w_alu_src_b = SrcBFour;
                case (bus.opcode)
                    OpR:             w_state_next = StExR;
                    OpI:             w_state_next = StExI;
                    OpLoad, OpStore: w_state_next = StExAddr;
                    OpBranch:        w_state_next = StExBr;
                    OpJal:           w_state_next = StExJal;
                    OpJalr:          w_state_next = StExJalr;
                    OpSystem:        w_state_next = StEcall;
                    default:         w_state_next = StTrap;
                endcase
            end
            StExR: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = AluFunct;
                w_state_next = StWbAlu;
            end
            StExI: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SrcBImm;
                w_alu_op     = AluFunct;
                w_state_next = StWbAlu;
            end
            StExAddr: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SrcBImm;
                w_state_next = (bus.opcode == OpStore) ? StMemSt : StMemLd;
            end
            StMemLd: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (bus.mem_ready) begin
                    w_state_next = StWbLd;
                end else if (w_timeout) begin
                    w_state_next = StTrap;
                end
            end
            StMemSt: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (bus.mem_ready) begin
                    w_pc_write   = 1'b1;
                    w_pc_src     = 1'b1;
                    w_state_next = StIf;
                end else if (w_timeout) begin
                    w_state_next = StTrap;
                end
            end
            StWbAlu, StWbLd: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_state == StWbLd);
                w_pc_write   = 1'b1;
                w_pc_src     = 1'b1;
                w_state_next = StIf;
            end
            StExBr: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = AluBr;
                if (bus.bcond) begin
                    w_state_next = StBrTake;
                end else begin
                    w_pc_write   = 1'b1;
                    w_pc_src     = 1'b1;
                    w_state_next = StIf;
                end
            end
            StBrTake: begin
                w_alu_src_b  = SrcBImm;
                w_pc_write   = 1'b1;
                w_state_next = StIf;
            end
            StExJal, StExJalr: begin
                // Link value PC+4 is already in ALUOut; the ALU computes the target
                w_alu_src_a  = (r_state == StExJalr);
                w_alu_src_b  = SrcBImm;
                w_reg_write  = 1'b1;
                w_pc_write   = 1'b1;
                w_state_next = StIf;
            end
            StEcall: begin
                if (bus.is_halt) begin
                    w_state_next = StHalt;
                end else begin
                    w_pc_write   = 1'b1;
                    w_pc_src     = 1'b1;
                    w_state_next = StIf;
                end
            end
            StHalt: begin
                w_halted = 1'b1;
            end
            StTrap: begin
                w_trapped = 1'b1;
            end
            default: begin
                w_state_next = StTrap;
            end
        endcase

        if (reset) begin
            w_pc_write  = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_ir_write  = 1'b0;
            w_reg_write = 1'b0;
            w_halted    = 1'b0;
            w_trapped   = 1'b0;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.IorD        = w_iord;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.mem_to_reg  = w_mem_to_reg;
    assign bus.ir_write    = w_ir_write;
    assign bus.pc_src      = w_pc_src;
    assign bus.alu_srcA    = w_alu_src_a;
    assign bus.reg_write   = w_reg_write;
    assign bus.halted      = w_halted;
    assign bus.trapped     = w_trapped;
    assign bus.mem_timeout = w_timeout && !reset;
    assign bus.alu_op      = w_alu_op;
    assign bus.alu_srcB    = w_alu_src_b;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: per-instruction expected cycle traces built from the instruction rules,
// compared against every output of multicycle_control_fsm each cycle.
module tb_multicycle_control_fsm;

    localparam int TW = 4;

    // Flag bits of the expected-output vector, MSB first in observed() order
    localparam logic [11:0] F_PCW  = 12'h800;
    localparam logic [11:0] F_IORD = 12'h400;
    localparam logic [11:0] F_MRD  = 12'h200;
    localparam logic [11:0] F_MWR  = 12'h100;
    localparam logic [11:0] F_M2R  = 12'h080;
    localparam logic [11:0] F_IRW  = 12'h040;
    localparam logic [11:0] F_PCS  = 12'h020;
    localparam logic [11:0] F_SA   = 12'h010;
    localparam logic [11:0] F_RW   = 12'h008;
    localparam logic [11:0] F_HLT  = 12'h004;
    localparam logic [11:0] F_TRP  = 12'h002;
    localparam logic [11:0] F_TO   = 12'h001;
    localparam logic [11:0] RST_MASK = F_PCW | F_MRD | F_MWR | F_IRW | F_RW | F_HLT | F_TRP | F_TO;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_ECALL = 7, K_ILL = 8;

    typedef struct {
        int          rdy;  // -1: drive random
        int          bc;
        int          hl;
        logic [19:0] vec;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.ALU_OP_W(2)) bus_if ();

    multicycle_control_fsm #(
        .ALU_OP_W (2),
        .TIMEOUT_W(TW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    cyc_t       q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         instr_no = 0;
    logic [6:0] cur_op;

    function automatic logic [19:0] observed();
        return {bus_if.pc_write, bus_if.IorD, bus_if.mem_read, bus_if.mem_write,
                bus_if.mem_to_reg, bus_if.ir_write, bus_if.pc_src, bus_if.alu_srcA,
                bus_if.reg_write, bus_if.halted, bus_if.trapped, bus_if.mem_timeout,
                bus_if.alu_op, bus_if.alu_srcB, bus_if.state};
    endfunction

    task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int st, input int rdy, input int bc, input int hl,
                        input logic [11:0] flags, input int op, input int sb);
        cyc_t c;
        logic [3:0] s4;
        logic [1:0] op2;
        logic [1:0] sb2;
        s4  = 4'(st);
        op2 = 2'(op);
        sb2 = 2'(sb);
        c.rdy = rdy;
        c.bc  = bc;
        c.hl  = hl;
        c.vec = {flags, op2, sb2, s4};
        q.push_back(c);
    endtask

    function automatic logic [6:0] opcode_of(input int kind);
        logic [6:0] op;
        case (kind)
            K_R:     op = 7'b0110011;
            K_I:     op = 7'b0010011;
            K_LD:    op = 7'b0000011;
            K_ST:    op = 7'b0100011;
            K_BR:    op = 7'b1100011;
            K_JAL:   op = 7'b1101111;
            K_JALR:  op = 7'b1100111;
            K_ECALL: op = 7'b1110011;
            default: begin
                op = 7'b1111111;
                if ($urandom_range(0, 1) == 1) begin
                    do op = 7'($urandom_range(0, 127));
                    while (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                      7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011});
                end
            end
        endcase
        return op;
    endfunction

    // Expected trace: fetch with fs stalls, decode, then the instruction's execute phases.
    task automatic build(input int kind, input int fs, input int ms, input int bc, input int hl);
        q.delete();
        cur_op = opcode_of(kind);
        repeat (fs) push(0, 0, -1, -1, F_MRD, 0, 0);
        push(0, 1, -1, -1, F_MRD | F_IRW, 0, 0);
        push(1, -1, -1, -1, 12'h0, 0, 1);
        case (kind)
            K_R, K_I: begin
                push((kind == K_R) ? 2 : 3, -1, -1, -1, F_SA, 1, (kind == K_R) ? 0 : 2);
                push(7, -1, -1, -1, F_RW | F_PCW | F_PCS, 0, 0);
            end
            K_LD: begin
                push(4, -1, -1, -1, F_SA, 0, 2);
                repeat (ms) push(5, 0, -1, -1, F_MRD | F_IORD, 0, 0);
                push(5, 1, -1, -1, F_MRD | F_IORD, 0, 0);
                push(8, -1, -1, -1, F_RW | F_M2R | F_PCW | F_PCS, 0, 0);
            end
            K_ST: begin
                push(4, -1, -1, -1, F_SA, 0, 2);
                repeat (ms) push(6, 0, -1, -1, F_MWR | F_IORD, 0, 0);
                push(6, 1, -1, -1, F_MWR | F_IORD | F_PCW | F_PCS, 0, 0);
            end
            K_BR: begin
                if (bc != 0) begin
                    push(9, -1, 1, -1, F_SA, 2, 0);
                    push(10, -1, -1, -1, F_PCW, 0, 2);
                end else begin
                    push(9, -1, 0, -1, F_SA | F_PCW | F_PCS, 2, 0);
                end
            end
            K_JAL:  push(11, -1, -1, -1, F_RW | F_PCW, 0, 2);
            K_JALR: push(12, -1, -1, -1, F_SA | F_RW | F_PCW, 0, 2);
            K_ECALL: begin
                if (hl != 0) begin
                    push(13, -1, -1, 1, 12'h0, 0, 0);
                    repeat (20) push(14, -1, -1, -1, F_HLT, 0, 0);
                end else begin
                    push(13, -1, -1, 0, F_PCW | F_PCS, 0, 0);
                end
            end
            default: repeat (3) push(15, -1, -1, -1, F_TRP, 0, 0);
        endcase
    endtask

    function automatic logic pick(input int v);
        return (v < 0) ? 1'($urandom_range(0, 1)) : (v != 0);
    endfunction

    // Called and returns at a falling edge; each record covers one clock cycle.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.mem_ready = pick(q[i].rdy);
            bus_if.bcond     = pick(q[i].bc);
            bus_if.is_halt   = pick(q[i].hl);
            bus_if.opcode    = cur_op;
            #1;
            check_eq($sformatf("instr%0d op%b cyc%0d", instr_no, cur_op, i), observed(), q[i].vec);
            @(negedge clk);
        end
        instr_no++;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus_if.mem_ready = 1'($urandom_range(0, 1));
        bus_if.bcond     = 1'($urandom_range(0, 1));
        bus_if.is_halt   = 1'($urandom_range(0, 1));
        bus_if.opcode    = 7'($urandom_range(0, 127));
        #1;
        check_eq("reset_strobes", observed() & {RST_MASK, 8'h00}, 20'h0);
        @(negedge clk);
        #1;
        check_eq("reset_state", observed() & {RST_MASK, 4'h0, 4'hF}, 20'h0);
        reset = 1'b0;
    endtask

    task automatic run_instr(input int kind, input int fs, input int ms, input int bc,
                             input int hl, input bit may_abort);
        int  n;
        bit  aborted;
        build(kind, fs, ms, bc, hl);
        n = q.size();
        aborted = 1'b0;
        if (may_abort && $urandom_range(0, 9) == 0) begin
            n = $urandom_range(1, q.size());
            aborted = 1'b1;
        end
        run(n);
        if (aborted || kind == K_ILL || (kind == K_ECALL && hl != 0)) begin
            do_reset();
        end
    endtask

    initial begin
        bus_if.opcode    = 7'h0;
        bus_if.bcond     = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.is_halt   = 1'b0;
        @(negedge clk);
        do_reset();

        // Directed scenarios
        run_instr(K_R, 0, 0, 0, 0, 1'b0);
        run_instr(K_LD, 0, 3, 0, 0, 1'b0);
        run_instr(K_ST, 2, 1, 0, 0, 1'b0);
        run_instr(K_BR, 0, 0, 0, 0, 1'b0);
        run_instr(K_BR, 0, 0, 1, 0, 1'b0);
        run_instr(K_JAL, 0, 0, 0, 0, 1'b0);
        run_instr(K_JALR, 1, 0, 0, 0, 1'b0);
        run_instr(K_ECALL, 0, 0, 0, 0, 1'b0);
        run_instr(K_ECALL, 0, 0, 0, 1, 1'b0);
        run_instr(K_ILL, 0, 0, 0, 0, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // Fetch never completes: pulse on the (2^TW-1)-th stalled cycle, then TRAP
        q.delete();
        cur_op = 7'b0110011;
        repeat ((1 << TW) - 2) push(0, 0, -1, -1, F_MRD, 0, 0);
        push(0, 0, -1, -1, F_MRD | F_TO, 0, 0);
        push(15, -1, -1, -1, F_TRP, 0, 0);
        push(15, -1, -1, -1, F_TRP, 0, 0);
        run(q.size());
        do_reset();
        // mem_ready arriving on that same cycle completes normally
        run_instr(K_R, (1 << TW) - 2, 0, 0, 0, 1'b0);
        run_instr(K_LD, 0, (1 << TW) - 2, 0, 0, 1'b0);
`else
        // No watchdog: long stalls simply wait
        run_instr(K_R, 40, 0, 0, 0, 1'b0);
        run_instr(K_ST, 0, 40, 0, 0, 1'b0);
`endif

        for (int k = 0; k < 300; k++) begin
            run_instr($urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
